// File: rtl/bcd_mod_counter_if.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_mod_counter_if
//  Purpose  : Control/data bundle for one bcd_mod_counter stage.
//             The master side (previous stage or controller) drives the
//             enable, direction and parallel-load request.
//             The slave side (the counter) returns the count, the terminal
//             count, the cascade carry/borrow and the load-error flag.
//  Signals  : en        count enable (cascade input)
//             up        direction, 1 = increment, 0 = decrement
//             load      synchronous parallel load request
//             load_val  packed BCD load value, digit 0 in [3:0]
//             count     registered packed BCD count
//             tc        combinational terminal count
//             co        combinational carry/borrow to the next stage
//             load_err  one-cycle pulse after a rejected load
//  Revision : 1.0  initial release
// ============================================================================
interface bcd_mod_counter_if #(
    parameter int DIGITS = 2
);
    logic                  en;
    logic                  up;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   count;
    logic                  tc;
    logic                  co;
    logic                  load_err;

    modport master (
        output en,
        output up,
        output load,
        output load_val,
        input  count,
        input  tc,
        input  co,
        input  load_err
    );

    modport slave (
        input  en,
        input  up,
        input  load,
        input  load_val,
        output count,
        output tc,
        output co,
        output load_err
    );
endinterface
`default_nettype wire

// File: rtl/bcd_mod_counter.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_mod_counter
//  Purpose  : Parametrised multi-digit packed-BCD modulo counter.
//             Counts 0..MODULUS-1, up or down, with synchronous range-checked
//             parallel load and a cascade carry/borrow output, so that
//             seconds/minutes/hours/day stages can be chained co -> en.
//  Params   : DIGITS   number of BCD digits (1..4)
//             MODULUS  count range 0..MODULUS-1 (2..10**DIGITS)
//  Ports    : clk      rising-edge clock
//             rst      synchronous reset, active-high
//             bus      bcd_mod_counter_if.slave (en, up, load, load_val in;
//                      count, tc, co, load_err out)
//  Priority : rst > load > en > hold, evaluated on every rising edge.
//  Revision : 1.0  initial release
// ============================================================================
module bcd_mod_counter #(
    parameter int DIGITS  = 2,
    parameter int MODULUS = 60
) (
    input  wire logic            clk,
    input  wire logic            rst,
    bcd_mod_counter_if.slave     bus
);

    localparam int c_width = 4 * DIGITS;

    // ------------------------------------------------------------------------
    // Parameter legality, rejected at elaboration
    // ------------------------------------------------------------------------
    generate
        if (DIGITS < 1 || DIGITS > 4) begin : g_bad_digits
            $error("bcd_mod_counter: DIGITS must be in 1..4");
        end
        if (MODULUS < 2 || MODULUS > 10 ** DIGITS) begin : g_bad_modulus
            $error("bcd_mod_counter: MODULUS must be in 2..10**DIGITS");
        end
    endgenerate

    // Binary-to-packed-BCD conversion, evaluated only on constants.
    function automatic logic [c_width-1:0] f_to_bcd(input int value);
        int                 v;
        logic [c_width-1:0] r;
        v = value;
        r = '0;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v           = v / 10;
        end
        return r;
    endfunction

    // Largest legal count. MODULUS itself may be 10**DIGITS, which does not
    // fit in DIGITS nibbles, so every range test is phrased against this.
    localparam logic [c_width-1:0] c_max_bcd = f_to_bcd(MODULUS - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [c_width-1:0] r_count;
    logic               r_load_err;

    // ------------------------------------------------------------------------
    // Terminal count and cascade carry/borrow (no register stage, so the
    // next stage sees co on the same edge on which this stage wraps)
    // ------------------------------------------------------------------------
    logic w_at_max;
    logic w_at_zero;
    logic w_tc;
    logic w_co;

    assign w_at_max  = (r_count == c_max_bcd);
    assign w_at_zero = (r_count == '0);
    assign w_tc      = bus.up ? w_at_max : w_at_zero;
    assign w_co      = bus.en & ~bus.load & w_tc;

    // ------------------------------------------------------------------------
    // Digit chain: digit k steps when every lower digit is at 9 (up) or at
    // 0 (down). Only meaningful away from the modulus boundary; the wrap
    // value below replaces it there.
    // ------------------------------------------------------------------------
    logic [c_width-1:0] w_step_val;
    logic               w_chain;
    logic [3:0]         w_dig;

    always_comb begin
        w_step_val = r_count;
        w_chain    = 1'b1;
        w_dig      = 4'd0;
        for (int k = 0; k < DIGITS; k++) begin
            w_dig = r_count[4*k +: 4];
            if (w_chain) begin
                if (bus.up) begin
                    w_step_val[4*k +: 4] = (w_dig == 4'd9) ? 4'd0 : w_dig + 4'd1;
                end else begin
                    w_step_val[4*k +: 4] = (w_dig == 4'd0) ? 4'd9 : w_dig - 4'd1;
                end
            end
            w_chain = w_chain & (bus.up ? (w_dig == 4'd9) : (w_dig == 4'd0));
        end
    end

    // Wrap target when stepping out of the terminal count.
    logic [c_width-1:0] w_wrap_val;
    assign w_wrap_val = bus.up ? '0 : c_max_bcd;

    // ------------------------------------------------------------------------
    // Load validation: all nibbles decimal and value below MODULUS. Once
    // every nibble is known to be 0..9 the packed BCD compares in the same
    // order as the decimal value, so a plain magnitude compare suffices.
    // ------------------------------------------------------------------------
    logic w_digits_ok;
    logic w_load_ok;

    always_comb begin
        w_digits_ok = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (bus.load_val[4*k +: 4] > 4'd9) begin
                w_digits_ok = 1'b0;
            end
        end
    end

    assign w_load_ok = w_digits_ok && (bus.load_val <= c_max_bcd);

    // ------------------------------------------------------------------------
    // Count register and load-error pulse
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count    <= '0;
            r_load_err <= 1'b0;
        end else if (bus.load) begin
            // en is ignored in a load cycle, accepted or not.
            if (w_load_ok) begin
                r_count    <= bus.load_val;
                r_load_err <= 1'b0;
            end else begin
                r_load_err <= 1'b1;
            end
        end else begin
            r_load_err <= 1'b0;
            if (bus.en) begin
                r_count <= w_tc ? w_wrap_val : w_step_val;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.count    = r_count;
    assign bus.load_err = r_load_err;
    assign bus.tc       = w_tc;
    assign bus.co       = w_co;

endmodule
`default_nettype wire
